// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// Lane merge helper is sized for the widest supported data path (64 bits).
package dmem_arb_pkg;

   typedef enum logic {ARB_IDLE = 1'b0, ARB_RMW = 1'b1} arb_state_e;

   localparam int unsigned MAX_DATA_W = 64;
   localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;
   localparam logic [MAX_BE_W-1:0] BE_FULL = '1;

   function automatic logic [MAX_DATA_W-1:0] byte_merge(
      input logic [MAX_DATA_W-1:0] old_data,
      input logic [MAX_DATA_W-1:0] new_data,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] r;
      for (int i = 0; i < MAX_BE_W; i++) begin
         r[i*8 +: 8] = be[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational per-byte merge of new store data over the current memory word.
module dmem_byte_merge
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic [DATA_W-1:0]   old_data,
   input  logic [DATA_W-1:0]   new_data,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   merged
);

   // Narrower paths are zero-extended into the 64-bit helper and trimmed back.
   assign merged = DATA_W'(byte_merge(MAX_DATA_W'(old_data), MAX_DATA_W'(new_data),
                                      MAX_BE_W'(be)));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-ported word-write data memory, with RMW byte stores.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority port 0 > port 1.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                p0_req,
   input  logic                p0_we,
   input  logic [ADDR_W-1:0]   p0_addr,
   input  logic [DATA_W-1:0]   p0_wdata,
   input  logic [DATA_W/8-1:0] p0_be,
   output logic                p0_ready,
   output logic                p0_rvalid,
   output logic [DATA_W-1:0]   p0_rdata,
   input  logic                p1_req,
   input  logic                p1_we,
   input  logic [ADDR_W-1:0]   p1_addr,
   input  logic [DATA_W-1:0]   p1_wdata,
   input  logic [DATA_W/8-1:0] p1_be,
   output logic                p1_ready,
   output logic                p1_rvalid,
   output logic [DATA_W-1:0]   p1_rdata,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_a,
   output logic [DATA_W-1:0]   mem_wd,
   input  logic [DATA_W-1:0]   mem_rd,
   output arb_state_e          dbg_state
);

   // Handshake: a request (req plus payload) is held until ready; ready is the
   // combinational grant and the transfer happens on the clock edge where both are high.
   localparam int unsigned BE_W = DATA_W / 8;

   arb_state_e          state, state_d;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [BE_W-1:0]     lat_be;
   logic [DATA_W-1:0]   merged;

   logic                any_req, sel_p1, sel_we, sel_full, accept;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [BE_W-1:0]     sel_be;

   assign any_req = p0_req | p1_req;

`ifdef DMEM_ARB_RR_EN
   logic rr_last;   // port granted most recently; the other one wins a tie

   assign sel_p1 = p1_req && (!p0_req || !rr_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last <= 1'b1;
      end else if (accept) begin
         rr_last <= sel_p1;
      end
   end
`else
   // Port 1 only gets through when port 0 is quiet and can starve.
   assign sel_p1 = p1_req && !p0_req;
`endif

   assign sel_we    = sel_p1 ? p1_we    : p0_we;
   assign sel_addr  = sel_p1 ? p1_addr  : p0_addr;
   assign sel_wdata = sel_p1 ? p1_wdata : p0_wdata;
   assign sel_be    = sel_p1 ? p1_be    : p0_be;
   assign sel_full  = (sel_be == BE_FULL[BE_W-1:0]);
   assign dbg_state = state;

   dmem_byte_merge #(.DATA_W(DATA_W)) u_merge (
      .old_data (mem_rd),
      .new_data (lat_wdata),
      .be       (lat_be),
      .merged   (merged)
   );

   always_comb begin
      state_d  = state;
      accept   = 1'b0;
      p0_ready = 1'b0;
      p1_ready = 1'b0;
      mem_we   = 1'b0;
      mem_a    = '0;
      mem_wd   = '0;
      // Gating on rst_n drops a pending RMW write the instant reset asserts.
      if (rst_n) begin
         case (state)
            ARB_IDLE: begin
               if (any_req) begin
                  accept   = 1'b1;
                  p0_ready = !sel_p1;
                  p1_ready = sel_p1;
                  mem_a    = sel_addr;
                  if (sel_we && sel_full) begin
                     mem_we = 1'b1;
                     mem_wd = sel_wdata;
                  end else if (sel_we && (sel_be != '0)) begin
                     state_d = ARB_RMW;
                  end
               end
            end
            ARB_RMW: begin
               mem_a   = lat_addr;
               mem_we  = 1'b1;
               mem_wd  = merged;
               state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB_IDLE;
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
      end else begin
         state     <= state_d;
         p0_rvalid <= accept && !sel_p1 && !sel_we;
         p1_rvalid <= accept && sel_p1 && !sel_we;
         if (accept && !sel_p1 && !sel_we) p0_rdata <= mem_rd;
         if (accept && sel_p1 && !sel_we)  p1_rdata <= mem_rd;
         if (state == ARB_IDLE && state_d == ARB_RMW) begin
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_be    <= sel_be;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural async-read memory.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic        clk, rst_n;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [7:0]  p0_be, p1_be;
   logic        p0_ready, p0_rvalid, p1_ready, p1_rvalid;
   logic [63:0] p0_rdata, p1_rdata;
   logic        mem_we;
   logic [63:0] mem_a, mem_wd, mem_rd;
   arb_state_e  dbg_state;

   logic [63:0] ram [1024];
   int          checks = 0;
   int          errors = 0;

   dmem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
      .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
      .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .dbg_state(dbg_state)
   );

   // clock / memory model
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign mem_rd = ram[mem_a[12:3]];

   always @(posedge clk) begin
      if (mem_we) ram[mem_a[12:3]] <= mem_wd;
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_be = '0;
      p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_be = '0;
   endtask

   task automatic drive_p0(input logic we, input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
      p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
   endtask

   task automatic drive_p1(input logic we, input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
      p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be;
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b", name, got, exp);
      end
   endtask

   task automatic check_word(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // scenarios
   task automatic test_reset();
      rst_n = 0;
      idle_all();
      #2;
      check_bit("rst_p0_ready", p0_ready, 1'b0);
      check_bit("rst_p1_ready", p1_ready, 1'b0);
      check_bit("rst_p0_rvalid", p0_rvalid, 1'b0);
      check_bit("rst_p1_rvalid", p1_rvalid, 1'b0);
      check_bit("rst_mem_we", mem_we, 1'b0);
      check_word("rst_p0_rdata", p0_rdata, 64'h0);
      check_word("rst_p1_rdata", p1_rdata, 64'h0);
      check_word("rst_mem_a", mem_a, 64'h0);
      check_word("rst_mem_wd", mem_wd, 64'h0);
      check_bit("rst_state", dbg_state, ARB_IDLE);
      step();
      rst_n = 1;
      step();
      check_bit("idle_p0_ready", p0_ready, 1'b0);
   endtask

   task automatic test_load();
      ram[2] = 64'h1122334455667788;
      drive_p0(1'b0, 64'h10, 64'h0, 8'h00);
      #1;
      check_bit("ld_p0_ready", p0_ready, 1'b1);
      check_bit("ld_p1_ready", p1_ready, 1'b0);
      check_word("ld_mem_a", mem_a, 64'h10);
      check_bit("ld_mem_we", mem_we, 1'b0);
      step();
      idle_all();
      #1;
      check_bit("ld_p0_rvalid", p0_rvalid, 1'b1);
      check_bit("ld_p1_rvalid", p1_rvalid, 1'b0);
      check_word("ld_p0_rdata", p0_rdata, 64'h1122334455667788);
      step();
      check_bit("ld_rvalid_pulse", p0_rvalid, 1'b0);
   endtask

   task automatic test_store_full();
      drive_p1(1'b1, 64'h18, 64'hDEADBEEFCAFEF00D, 8'hFF);
      #1;
      check_bit("st_p1_ready", p1_ready, 1'b1);
      check_bit("st_mem_we", mem_we, 1'b1);
      check_word("st_mem_wd", mem_wd, 64'hDEADBEEFCAFEF00D);
      check_word("st_mem_a", mem_a, 64'h18);
      step();
      drive_p1(1'b0, 64'h18, 64'h0, 8'h00);
      #1;
      check_bit("st_rvalid_none", p1_rvalid, 1'b0);
      check_bit("haz_p1_ready", p1_ready, 1'b1);
      step();
      idle_all();
      #1;
      check_bit("haz_p1_rvalid", p1_rvalid, 1'b1);
      check_word("haz_p1_rdata", p1_rdata, 64'hDEADBEEFCAFEF00D);
      check_word("st_ram3", ram[3], 64'hDEADBEEFCAFEF00D);
   endtask

   task automatic test_rmw();
      ram[0] = '1;
      step();
      drive_p0(1'b1, 64'h0, 64'hAB, 8'h01);
      #1;
      check_bit("rmw_n_p0_ready", p0_ready, 1'b1);
      check_bit("rmw_n_mem_we", mem_we, 1'b0);
      step();
      idle_all();
      drive_p1(1'b0, 64'h0, 64'h0, 8'h00);
      #1;
      check_bit("rmw_state", dbg_state, ARB_RMW);
      check_bit("rmw_mem_we", mem_we, 1'b1);
      check_word("rmw_mem_wd", mem_wd, 64'hFFFFFFFFFFFFFFAB);
      check_word("rmw_mem_a", mem_a, 64'h0);
      check_bit("rmw_p1_ready", p1_ready, 1'b0);
      check_bit("rmw_p0_ready", p0_ready, 1'b0);
      step();
      #1;
      check_word("rmw_ram0", ram[0], 64'hFFFFFFFFFFFFFFAB);
      check_bit("rmw_after_p1_ready", p1_ready, 1'b1);
      check_bit("rmw_after_state", dbg_state, ARB_IDLE);
      step();
      idle_all();
      #1;
      check_word("rmw_readback", p1_rdata, 64'hFFFFFFFFFFFFFFAB);
   endtask

   task automatic test_arbitration();
      logic [3:0] exp_p1;
      logic       prev_p1;
`ifdef DMEM_ARB_RR_EN
      exp_p1 = 4'b1010;
`else
      exp_p1 = 4'b0000;
`endif
      prev_p1 = 1'b0;
      step();
      drive_p0(1'b0, 64'h10, 64'h0, 8'h00);
      drive_p1(1'b0, 64'h18, 64'h0, 8'h00);
      for (int k = 0; k < 5; k++) begin
         #1;
         if (k > 0) begin
            check_bit($sformatf("arb_p0_rvalid_%0d", k), p0_rvalid, !prev_p1);
            check_bit($sformatf("arb_p1_rvalid_%0d", k), p1_rvalid, prev_p1);
            check_word($sformatf("arb_rdata_%0d", k), prev_p1 ? p1_rdata : p0_rdata,
                       prev_p1 ? 64'hDEADBEEFCAFEF00D : 64'h1122334455667788);
         end
         if (k < 4) begin
            check_bit($sformatf("arb_p1_grant_%0d", k), p1_ready, exp_p1[k]);
            check_bit($sformatf("arb_p0_grant_%0d", k), p0_ready, !exp_p1[k]);
            prev_p1 = exp_p1[k];
            step();
            if (k == 3) idle_all();
         end
      end
   endtask

   task automatic test_reset_rmw();
      step();
      drive_p0(1'b1, 64'h0, 64'h0, 8'h02);
      step();
      idle_all();
      #1;
      check_bit("rr_state_rmw", dbg_state, ARB_RMW);
      check_bit("rr_we_before", mem_we, 1'b1);
      rst_n = 0;
      #1;
      check_bit("rr_we_abandon", mem_we, 1'b0);
      check_bit("rr_state_idle", dbg_state, ARB_IDLE);
      check_word("rr_mem_a", mem_a, 64'h0);
      check_word("rr_mem_wd", mem_wd, 64'h0);
      check_word("rr_p1_rdata", p1_rdata, 64'h0);
      check_word("rr_p0_rdata", p0_rdata, 64'h0);
      step();
      check_word("rr_ram0_kept", ram[0], 64'hFFFFFFFFFFFFFFAB);
      rst_n = 1;
      step();
      check_bit("rr_post_state", dbg_state, ARB_IDLE);
      check_bit("rr_post_we", mem_we, 1'b0);
   endtask

   task automatic test_be_zero();
      ram[4] = 64'h0123456789ABCDEF;
      drive_p1(1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      #1;
      check_bit("bz_p1_ready", p1_ready, 1'b1);
      check_bit("bz_mem_we", mem_we, 1'b0);
      step();
      idle_all();
      #1;
      check_bit("bz_mem_we_next", mem_we, 1'b0);
      check_bit("bz_state", dbg_state, ARB_IDLE);
      check_bit("bz_rvalid", p1_rvalid, 1'b0);
      step();
      check_word("bz_ram4", ram[4], 64'h0123456789ABCDEF);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      test_reset();
      test_load();
      test_store_full();
      test_rmw();
      test_arbitration();
      test_be_zero();
      test_reset_rmw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
